// File: rtl/signed_upscaler.sv
// Two-stage signed left-shift scaler with output saturation and a saturation counter.
// Optional LFSR dither of the vacated LSBs is enabled by defining SIGNED_UPSCALER_DITHER_EN.
module signed_upscaler #(
    parameter int unsigned DATA_WIDTH_IN  = 16,
    parameter int unsigned DATA_WIDTH_OUT = 24,
    parameter int unsigned SHIFT_W        = 4
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [DATA_WIDTH_IN-1:0]  din,
    input  logic [SHIFT_W-1:0]        shift,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [DATA_WIDTH_OUT-1:0] dout,
    output logic [15:0]               sat_count,
    input  logic                      sat_clr
);

    localparam int unsigned PROD_W = DATA_WIDTH_IN + (1 << SHIFT_W) - 1;
    localparam int unsigned CALC_W = (PROD_W > DATA_WIDTH_OUT) ? PROD_W : DATA_WIDTH_OUT;

    // Output range limits expressed at the internal calculation width.
    localparam logic signed [CALC_W-1:0] MAXVAL =
        signed'({{(CALC_W - DATA_WIDTH_OUT + 1){1'b0}}, {(DATA_WIDTH_OUT - 1){1'b1}}});
    localparam logic signed [CALC_W-1:0] MINVAL = ~MAXVAL;

    generate
        if (DATA_WIDTH_OUT < DATA_WIDTH_IN) begin : g_width_check
            $error("signed_upscaler: DATA_WIDTH_OUT must be >= DATA_WIDTH_IN");
        end
    endgenerate

    logic                      adv;
    logic                      s1_valid;
    logic signed [CALC_W-1:0]  s1_din;
    logic [SHIFT_W-1:0]        s1_shift;
    logic signed [CALC_W-1:0]  prod;
    logic                      sat_hi;
    logic                      sat_lo;
    logic                      sat_event;
    logic [DATA_WIDTH_OUT-1:0] res;

    assign adv       = !out_valid || out_ready;
    assign in_ready  = adv;
    assign sat_event = adv && s1_valid && (sat_hi || sat_lo);

`ifdef SIGNED_UPSCALER_DITHER_EN
    logic [15:0]       lfsr;
    logic [15:0]       s1_lfsr;
    logic [CALC_W-1:0] dith;
`endif

    // S2 datapath: full-precision shift, range check, optional dither.
    always_comb begin
        prod   = s1_din <<< s1_shift;
        sat_hi = (prod > MAXVAL);
        sat_lo = (prod < MINVAL);
`ifdef SIGNED_UPSCALER_DITHER_EN
        dith   = CALC_W'(s1_lfsr) & ((CALC_W'(1) << s1_shift) - CALC_W'(1));
        res    = DATA_WIDTH_OUT'(prod | dith);
`else
        res    = DATA_WIDTH_OUT'(prod);
`endif
        if (sat_hi) begin
            res = MAXVAL[DATA_WIDTH_OUT-1:0];
        end else if (sat_lo) begin
            res = MINVAL[DATA_WIDTH_OUT-1:0];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid  <= 1'b0;
            s1_din    <= '0;
            s1_shift  <= '0;
            out_valid <= 1'b0;
            dout      <= '0;
            sat_count <= '0;
`ifdef SIGNED_UPSCALER_DITHER_EN
            lfsr      <= 16'hACE1;
            s1_lfsr   <= '0;
`endif
        end else begin
            if (adv) begin
                s1_valid  <= in_valid;
                out_valid <= s1_valid;
                if (in_valid) begin
                    s1_din   <= CALC_W'(signed'(din));
                    s1_shift <= shift;
`ifdef SIGNED_UPSCALER_DITHER_EN
                    // Sample keeps the pre-advance LFSR state for its dither bits.
                    s1_lfsr  <= lfsr;
                    lfsr     <= {lfsr[0] ^ lfsr[2] ^ lfsr[3] ^ lfsr[5], lfsr[15:1]};
`endif
                end
                if (s1_valid) begin
                    dout <= res;
                end
            end
            // Clear has priority over a coincident saturation event.
            if (sat_clr) begin
                sat_count <= '0;
            end else if (sat_event && (sat_count != 16'hFFFF)) begin
                sat_count <= sat_count + 16'd1;
            end
        end
    end

endmodule

// File: tb/tb_signed_upscaler.sv
// Self-checking bench for signed_upscaler: directed table, corner sequences, random vs. reference model.
module tb_signed_upscaler;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] din;
    logic [3:0]  shift;
    logic        out_valid;
    logic        out_ready;
    logic [23:0] dout;
    logic [15:0] sat_count;
    logic        sat_clr;

    signed_upscaler dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .din       (din),
        .shift     (shift),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .dout      (dout),
        .sat_count (sat_count),
        .sat_clr   (sat_clr)
    );

    always #5 clk = ~clk;

    localparam longint MAXV = (64'sd1 <<< 23) - 64'sd1;
    localparam longint MINV = -(64'sd1 <<< 23);

    typedef struct {
        logic [15:0] din;
        logic [3:0]  shift;
        logic [23:0] dout;
        logic        sat;
        int          sat_cnt;
    } vec_t;

    vec_t        tbl[13];
    int          checks = 0;
    int          errors = 0;
    logic [23:0] exp_q[$];
    logic [23:0] out_log[$];
    logic [15:0] lfsr_m = 16'hACE1;
    logic [15:0] last_lfsr;
    int          sat_m = 0;
    logic        in_xfer, out_xfer, last_in_ready, last_out_valid;
    logic [23:0] last_dout;

    function automatic longint raw_prod(input logic [15:0] d, input logic [3:0] s);
        return longint'($signed(d)) * (64'sd1 <<< s);
    endfunction

    function automatic logic is_sat(input logic [15:0] d, input logic [3:0] s);
        longint p = raw_prod(d, s);
        return (p > MAXV) || (p < MINV);
    endfunction

    function automatic logic [23:0] ref_out(input logic [15:0] d, input logic [3:0] s,
                                            input logic [15:0] l);
        longint      p = raw_prod(d, s);
        logic [15:0] m = (16'd1 << s) - 16'd1;
        if (p > MAXV) return 24'h7FFFFF;
        if (p < MINV) return 24'h800000;
`ifdef SIGNED_UPSCALER_DITHER_EN
        p = p + longint'(l & m);
`else
        if ((l & m & 16'd0) != 16'd0) p = 0;
`endif
        return p[23:0];
    endfunction

    function automatic logic [15:0] lfsr_next(input logic [15:0] l);
        logic fb = l[0] ^ l[2] ^ l[3] ^ l[5];
        return {fb, l[15:1]};
    endfunction

    task automatic check(input string name, input longint got, input longint want);
        checks++;
        if (got != want) begin
            errors++;
            $display("FAIL %s: got %0h, required %0h", name, got, want);
        end
    endtask

    // One clock cycle: observe transfers just before the edge, update the model, step to negedge.
    task automatic tick();
        logic [23:0] e;
        #2;
        in_xfer        = 1'b0;
        out_xfer       = 1'b0;
        last_in_ready  = in_ready;
        last_out_valid = out_valid;
        if (rst) begin
            exp_q.delete();
            lfsr_m = 16'hACE1;
            sat_m  = 0;
        end else begin
            if (out_valid && out_ready) begin
                out_xfer  = 1'b1;
                last_dout = dout;
                out_log.push_back(dout);
                if (exp_q.size() == 0) begin
                    check("unexpected_output", longint'(dout), -1);
                end else begin
                    e = exp_q.pop_front();
                    check("model_dout", longint'(dout), longint'(e));
                end
            end
            if (in_valid && in_ready) begin
                in_xfer   = 1'b1;
                last_lfsr = lfsr_m;
                exp_q.push_back(ref_out(din, shift, lfsr_m));
                if (is_sat(din, shift) && sat_m < 65535) sat_m++;
                lfsr_m = lfsr_next(lfsr_m);
            end
        end
        @(negedge clk);
    endtask

    // Push one sample into an idle pipe with out_ready high; report output and latency.
    task automatic send(input logic [15:0] d, input logic [3:0] s,
                        output logic [23:0] got, output int lat);
        int n = 0;
        din = d; shift = s; in_valid = 1'b1; out_ready = 1'b1;
        do begin
            tick();
            n++;
        end while (!in_xfer && n < 20);
        in_valid = 1'b0;
        lat = 0;
        got = 24'hxxxxxx;
        while (lat < 20) begin
            tick();
            lat++;
            if (out_xfer) begin
                got = last_dout;
                break;
            end
        end
    endtask

    initial begin
        logic [23:0] got, want;
        logic [15:0] dm;
        int          lat, k, cyc, nlog;

        tbl[0]  = '{16'h0000, 4'd4,  24'h000000, 1'b0, 0};
        tbl[1]  = '{16'h1234, 4'd4,  24'h012340, 1'b0, 0};
        tbl[2]  = '{16'hFFFF, 4'd8,  24'hFFFF00, 1'b0, 0};
        tbl[3]  = '{16'h8000, 4'd8,  24'h800000, 1'b0, 0};
        tbl[4]  = '{16'h7FFF, 4'd9,  24'h7FFFFF, 1'b1, 1};
        tbl[5]  = '{16'h8000, 4'd9,  24'h800000, 1'b1, 2};
        tbl[6]  = '{16'hC000, 4'd9,  24'h800000, 1'b0, 2};
        tbl[7]  = '{16'h4000, 4'd9,  24'h7FFFFF, 1'b1, 3};
        tbl[8]  = '{16'h8001, 4'd8,  24'h800100, 1'b0, 3};
        tbl[9]  = '{16'h0001, 4'd15, 24'h008000, 1'b0, 3};
        tbl[10] = '{16'hFFFF, 4'd15, 24'hFF8000, 1'b0, 3};
        tbl[11] = '{16'h7FFF, 4'd15, 24'h7FFFFF, 1'b1, 4};
        tbl[12] = '{16'h3FFF, 4'd9,  24'h7FFE00, 1'b0, 4};

        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1; sat_clr = 1'b0;
        din = '0; shift = '0;
        @(negedge clk);
        tick(); tick();
        #2;
        check("reset_out_valid", longint'(out_valid), 0);
        check("reset_dout", longint'(dout), 0);
        check("reset_sat_count", longint'(sat_count), 0);
        @(negedge clk);
        rst = 1'b0;
        tick();
        check("in_ready_after_reset", longint'(last_in_ready), 1);

        // Directed table; the first row is also the first sample after reset.
        for (int i = 0; i < 13; i++) begin
            send(tbl[i].din, tbl[i].shift, got, lat);
            want = tbl[i].dout;
`ifdef SIGNED_UPSCALER_DITHER_EN
            dm = (16'd1 << tbl[i].shift) - 16'd1;
            if (!tbl[i].sat) want = want | 24'(last_lfsr & dm);
`else
            dm = 16'd0;
`endif
            check($sformatf("tbl%0d_dout", i), longint'(got), longint'(want));
            check($sformatf("tbl%0d_latency", i), longint'(lat), 2);
            check($sformatf("tbl%0d_sat_count", i), longint'(sat_count), longint'(tbl[i].sat_cnt) + longint'(dm & 16'd0));
        end

        // Clear coincident with a saturation entering S2.
        din = 16'h7FFF; shift = 4'd9; in_valid = 1'b1; out_ready = 1'b1;
        tick();
        check("clr_seq_accept", longint'(in_xfer), 1);
        in_valid = 1'b0; sat_clr = 1'b1;
        tick();
        sat_clr = 1'b0;
        tick(); tick();
        check("clr_wins_sat_count", longint'(sat_count), 0);
        sat_m = 0;

        // Backpressure: ten samples, out_ready low for five cycles mid-stream.
        out_log.delete();
        k = 1; cyc = 0;
        while (k <= 10 && cyc < 100) begin
            din = 16'(k); shift = 4'd0; in_valid = 1'b1;
            out_ready = !(cyc >= 4 && cyc < 9);
            tick();
            if (cyc >= 4 && cyc < 9) check("stall_in_ready", longint'(last_in_ready), 0);
            if (in_xfer) k++;
            cyc++;
        end
        in_valid = 1'b0; out_ready = 1'b1;
        for (int i = 0; i < 10; i++) tick();
        nlog = out_log.size();
        check("bp_output_count", longint'(nlog), 10);
        for (int i = 0; i < 10 && i < nlog; i++)
            check($sformatf("bp_order%0d", i), longint'(out_log[i]), longint'(i + 1));

        // Reset with both stages valid.
        din = 16'h0055; shift = 4'd1; in_valid = 1'b1; out_ready = 1'b1;
        tick(); tick();
        rst = 1'b1;
        tick();
        rst = 1'b0; in_valid = 1'b0;
        tick();
        check("post_reset_out_valid", longint'(last_out_valid), 0);
        check("post_reset_in_ready", longint'(last_in_ready), 1);
        send(16'h0100, 4'd2, got, lat);
        want = 24'h000400;
`ifdef SIGNED_UPSCALER_DITHER_EN
        want = want | 24'h000001;
`endif
        check("post_reset_dout", longint'(got), longint'(want));
        check("post_reset_latency", longint'(lat), 2);
        tick();
        check("post_reset_sat_count", longint'(sat_count), 0);

        // Random traffic against the reference model.
        for (int i = 0; i < 400; i++) begin
            in_valid  = ($urandom_range(0, 9) < 7);
            out_ready = ($urandom_range(0, 9) < 7);
            din       = 16'($urandom);
            shift     = 4'($urandom_range(0, 15));
            tick();
        end
        in_valid = 1'b0; out_ready = 1'b1;
        for (int i = 0; i < 6; i++) tick();
        check("rand_drained", longint'(exp_q.size()), 0);
        check("rand_sat_count", longint'(sat_count), longint'(sat_m));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout, required completion");
        $fatal(1, "watchdog");
    end

endmodule
